clk_switch_ctrl: RTL and testbench
==================================

CLK_SWITCH_CTRL -- requirements
Module: clk_switch_ctrl

Interface
REQ-001 SHALL have parameter LOCK_CYCLES, default 16: consecutive cycles of synchronized src1_ok required before switching to source 1.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 8: cycles to hold after a sel change before completion.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024: maximum cycles spent qualifying source 1.
REQ-004 SHALL have port clk  input  1  single clock; all logic on posedge clk.
REQ-005 SHALL have port rst  input  1  synchronous reset, active-high.
REQ-006 SHALL have port req_valid  input  1  switch request valid.
REQ-007 SHALL have port req_sel  input  1  requested source (0 = clk0, 1 = clk1).
REQ-008 SHALL have port req_ready  output  1  controller can accept a request.
REQ-009 SHALL have port src1_ok  input  1  asynchronous lock/stable flag of the clk1 source.
REQ-010 SHALL have port sel  output  1  registered select driven to the downstream glitch-free clock mux.
REQ-011 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-012 SHALL have port done  output  1  one-cycle pulse: request completed.
REQ-013 SHALL have port err  output  1  one-cycle pulse: qualification timeout; sel unchanged.
REQ-014 SHALL have port fault  output  1  one-cycle pulse: automatic fallback to source 0.

Function
REQ-015 SHALL pass src1_ok through a 2-flop synchronizer (src1_ok_s); all decisions use src1_ok_s.
REQ-016 SHALL implement states IDLE, QUAL, SETTLE, DONE.
REQ-017 SHALL set req_ready = (state==IDLE) & ~fallback_cond, combinationally; fallback_cond = sel & ~src1_ok_s.
REQ-018 SHALL accept a request on a cycle with req_valid & req_ready and latch req_sel as target.
REQ-019 SHALL, on acceptance with target==sel, go IDLE->DONE; done pulses the next cycle; sel unchanged.
REQ-020 SHALL, on acceptance with target=0 and sel=1, set sel<=0 and enter SETTLE on the next edge.
REQ-021 SHALL, on acceptance with target=1 and sel=0, enter QUAL with lock and timeout counters cleared.
REQ-022 SHALL in QUAL increment the lock counter each cycle src1_ok_s=1 and clear it each cycle src1_ok_s=0.
REQ-023 SHALL leave QUAL when the lock counter reaches LOCK_CYCLES-1 with src1_ok_s=1: sel<=1, state SETTLE.
REQ-024 SHALL count every QUAL cycle with the timeout counter; on reaching TIMEOUT_CYCLES-1 without lock: err pulse, state IDLE, sel unchanged; lock success in the same cycle takes priority.
REQ-025 SHALL in SETTLE count SETTLE_CYCLES cycles, then enter DONE; DONE lasts one cycle with done=1, then IDLE.
REQ-026 SHALL in IDLE, when fallback_cond is true, set sel<=0, pulse fault, and enter SETTLE; the completion done pulse still follows.
REQ-027 SHALL ignore src1_ok_s changes during SETTLE and DONE; fallback is evaluated only in IDLE.
REQ-028 SHALL size counters to clog2 of their parameter; counters saturate, never wrap.
REQ-029 SHALL change sel only on the transitions in REQ-020, REQ-023 and REQ-026.

Reset
REQ-030 SHALL on rst=1 set state IDLE, sel=0, done=err=fault=0, busy=0, synchronizer flops 0, counters 0.
REQ-031 SHALL, when rst is asserted mid-operation, abandon the operation at the next edge with no done/err/fault pulse.

Verification
REQ-032 SHALL verify: src1_ok=1 steady, request sel=1 accepted at cycle T -> sel rises at T+17 (earlier if already synced), done pulses at T+26, busy high T+1..T+26.
REQ-033 SHALL verify: src1_ok=0, request sel=1 -> err pulses once at T+1024, sel stays 0, req_ready returns 1.
REQ-034 SHALL verify: src1_ok toggles low at lock count 10 in QUAL -> lock counter clears; sel rises only after 16 fresh consecutive high cycles.
REQ-035 SHALL verify: sel=1 in IDLE, src1_ok drops -> fault pulses 3 cycles later, sel=0, done 9 cycles after fault.
REQ-036 SHALL verify: request equal to current sel -> done the next cycle, sel unchanged; req_valid while busy is not accepted.
REQ-037 SHALL verify: rst pulsed during SETTLE -> sel=0, state IDLE, no done pulse.

Source files
------------

// File: rtl/clk_switch_ctrl.sv
// rtl/clk_switch_ctrl.sv - clock source switch sequencer for a glitch-free clock mux
//
// Purpose: accepts requests to move the downstream clock mux between clk0 and
// clk1. Switching to clk1 first qualifies the clk1 source. Its lock flag must be
// seen high for LOCK_CYCLES consecutive cycles, and qualification gives up after
// TIMEOUT_CYCLES. Every sel change is followed by a settle window, then a done
// pulse. If clk1 loses lock while selected, the block falls back to clk0 on its own.
//
// Ports:
//   clk        in   single clock, all logic on posedge
//   rst        in   synchronous reset, active-high
//   req_valid  in   switch request valid
//   req_sel    in   requested source (0 = clk0, 1 = clk1)
//   req_ready  out  request can be accepted this cycle
//   src1_ok    in   asynchronous lock/stable flag of the clk1 source
//   sel        out  registered select to the clock mux
//   busy       out  high whenever the sequencer is not idle
//   done       out  one-cycle pulse: request (or fallback) completed
//   err        out  one-cycle pulse: clk1 qualification timed out, sel unchanged
//   fault      out  one-cycle pulse: automatic fallback to clk0
module clk_switch_ctrl #(
  parameter int LOCK_CYCLES    = 16,
  parameter int SETTLE_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic req_valid,
  input  logic req_sel,
  output logic req_ready,
  input  logic src1_ok,
  output logic sel,
  output logic busy,
  output logic done,
  output logic err,
  output logic fault
);

  localparam int LW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  // The settle counter must reach SETTLE_CYCLES itself, so it needs room for that value.
  localparam int SW = $clog2(SETTLE_CYCLES + 1);

  localparam logic [LW-1:0] LOCK_LAST   = LW'(LOCK_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST     = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    QUAL   = 2'd1,
    SETTLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic            sync1_q, sync2_q;
  logic            sel_q, sel_d;
  logic            fault_q, fault_d;
  logic            err_c;
  logic [LW-1:0]   lock_q, lock_d;
  logic [TW-1:0]   to_q, to_d;
  logic [SW-1:0]   settle_q, settle_d;
  logic            src1_ok_s;
  logic            fallback_cond;
  logic            lock_hit;

  assign src1_ok_s     = sync2_q;
  assign fallback_cond = sel_q & ~src1_ok_s;
  assign lock_hit      = src1_ok_s & (lock_q == LOCK_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      sel_q    <= 1'b0;
      fault_q  <= 1'b0;
      lock_q   <= '0;
      to_q     <= '0;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      sync1_q  <= src1_ok;
      sync2_q  <= sync1_q;
      sel_q    <= sel_d;
      fault_q  <= fault_d;
      lock_q   <= lock_d;
      to_q     <= to_d;
      settle_q <= settle_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    fault_d  = 1'b0;
    err_c    = 1'b0;
    lock_d   = lock_q;
    to_d     = to_q;
    settle_d = settle_q;
    case (state_q)
      IDLE: begin
        lock_d   = '0;
        to_d     = '0;
        settle_d = '0;
        // Fallback blocks req_ready, so it always wins over a pending request.
        if (fallback_cond) begin
          sel_d   = 1'b0;
          fault_d = 1'b1;
          state_d = SETTLE;
        end else if (req_valid) begin
          if (req_sel == sel_q) begin
            state_d = DONE;
          end else if (!req_sel) begin
            sel_d   = 1'b0;
            state_d = SETTLE;
          end else begin
            state_d = QUAL;
          end
        end
      end
      QUAL: begin
        if (to_q != TO_LAST) to_d = to_q + 1'b1;
        if (lock_hit) begin
          sel_d   = 1'b1;
          state_d = SETTLE;
        end else begin
          if (src1_ok_s) lock_d = lock_q + 1'b1;
          else           lock_d = '0;
          if (to_q == TO_LAST) begin
            err_c   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      SETTLE: begin
        // The cycle in which sel changes is not counted; SETTLE_CYCLES full cycles follow it.
        if (settle_q == SETTLE_LAST) state_d = DONE;
        else                         settle_d = settle_q + 1'b1;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign req_ready = (state_q == IDLE) & ~fallback_cond;
  assign sel       = sel_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  // err is decided from registered state only; a reset in that cycle abandons it.
  assign err       = err_c & ~rst;
  assign fault     = fault_q;

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// tb/tb_clk_switch_ctrl.sv - directed self-checking bench for clk_switch_ctrl
module tb_clk_switch_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic req_valid;
  logic req_sel;
  logic req_ready;
  logic src1_ok;
  logic sel;
  logic busy;
  logic done;
  logic err;
  logic fault;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  clk_switch_ctrl #(
    .LOCK_CYCLES(16),
    .SETTLE_CYCLES(8),
    .TIMEOUT_CYCLES(1024)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_sel(req_sel),
    .req_ready(req_ready),
    .src1_ok(src1_ok),
    .sel(sel),
    .busy(busy),
    .done(done),
    .err(err),
    .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  int err_cnt;
  int err_at;
  int sel_hi;
  int done_cnt;

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    req_sel = 1'b0;
    src1_ok = 1'b1;
    repeat (3) tick();
    chk("rst_sel", sel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_fault", fault, 0);
    chk("rst_ready", req_ready, 1);
    rst = 1'b0;
    repeat (4) tick();

    // Switch to clk1 with src1_ok steady high; a request while busy is ignored.
    req_valid = 1'b1; req_sel = 1'b1;
    chk("t1_ready", req_ready, 1);
    for (int i = 1; i <= 30; i++) begin
      tick();
      req_valid = 1'b0;
      chk("t1_busy", busy, (i <= 26));
      chk("t1_sel", sel, (i >= 17));
      chk("t1_done", done, (i == 26));
      chk("t1_err", err, 0);
      if (i == 5) begin
        chk("t1_busy_ready", req_ready, 0);
        req_valid = 1'b1; req_sel = 1'b0;
      end
    end

    // clk1 loses lock while selected: automatic fallback.
    src1_ok = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      tick();
      chk("fb_fault", fault, (i == 3));
      chk("fb_sel", sel, (i <= 2));
      chk("fb_done", done, (i == 12));
      if (i == 2) chk("fb_ready", req_ready, 0);
    end

    // Qualification timeout with src1_ok low.
    req_valid = 1'b1; req_sel = 1'b1;
    chk("to_ready0", req_ready, 1);
    err_cnt = 0; err_at = 0; sel_hi = 0;
    for (int i = 1; i <= 1030; i++) begin
      tick();
      req_valid = 1'b0;
      if (err) begin err_cnt++; err_at = i; end
      if (sel) sel_hi++;
      if (i == 1024) chk("to_busy_last", busy, 1);
      if (i == 1025) chk("to_busy_after", busy, 0);
    end
    chk("to_err_cnt", err_cnt, 1);
    chk("to_err_at", err_at, 1024);
    chk("to_sel_hi", sel_hi, 0);
    chk("to_ready", req_ready, 1);

    // Lock flag glitches low at lock count 10; lock must restart.
    src1_ok = 1'b1;
    repeat (3) tick();
    req_valid = 1'b1; req_sel = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      req_valid = 1'b0;
      if (i == 9)  src1_ok = 1'b0;
      if (i == 10) src1_ok = 1'b1;
      chk("lk_sel", sel, (i >= 28));
      chk("lk_done", done, (i == 37));
      chk("lk_fault", fault, 0);
    end

    // Request equal to current sel completes next cycle.
    req_valid = 1'b1; req_sel = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("eq_done", done, 1);
    chk("eq_busy", busy, 1);
    chk("eq_sel", sel, 1);
    tick();
    chk("eq_done_off", done, 0);
    chk("eq_busy_off", busy, 0);

    // Switch back to clk0: sel drops immediately, then settle.
    req_valid = 1'b1; req_sel = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      tick();
      req_valid = 1'b0;
      chk("to0_sel", sel, 0);
      chk("to0_done", done, (i == 10));
      chk("to0_busy", busy, (i <= 10));
    end

    // Reset pulsed during SETTLE abandons the operation without a done pulse.
    req_valid = 1'b1; req_sel = 1'b1;
    done_cnt = 0;
    for (int i = 1; i <= 45; i++) begin
      tick();
      req_valid = 1'b0;
      if (done) done_cnt++;
      if (i == 20) begin
        chk("rs_sel_pre", sel, 1);
        chk("rs_busy_pre", busy, 1);
        rst = 1'b1;
      end
      if (i == 21) begin
        chk("rs_sel", sel, 0);
        chk("rs_busy", busy, 0);
        chk("rs_done", done, 0);
        chk("rs_fault", fault, 0);
        rst = 1'b0;
      end
      if (i > 21) chk("rs_idle", busy, 0);
    end
    chk("rs_done_cnt", done_cnt, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
